lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator for the MEM stage: turns a pipeline load/store request into a chip-select/write-enable/byte-mask
//  access on the data-memory bus, and waits for the memory's ready handshake.
//  Aligns store data and lanes; extracts and sign/zero-extends load data. Stalls the pipeline until the access completes.
//  Reports misaligned-access and bus-timeout errors to the CSR/trap logic.
// PARAMETERS
//  ADDR_W   32  byte-address width on request and bus
//  TIMEOUT  16  max cycles waiting for mem_ready per beat before bus error (>=1)
// PORTS
//  clk           in   1       clock; all state on posedge
//  rst           in   1       asynchronous, active-high reset
//  req_valid     in   1       MEM-stage instruction is a load or store
//  req_store     in   1       1=store, 0=load
//  req_funct3    in   3       RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr      in   ADDR_W  byte address (ALU result)
//  req_wdata     in   32      store data (rs2), right-aligned
//  stall         out  1       hold pipeline; combinational
//  resp_valid    out  1       one-cycle pulse: access finished
//  load_data     out  32      extended load result; valid with resp_valid
//  err_misalign  out  1       with resp_valid: misaligned, no bus access made
//  err_bus       out  1       with resp_valid: timeout
//  err_illegal   out  1       with resp_valid: funct3 011/110/111 (or 1xx on store)
//  mem_cs_n      out  1       bus chip select, active low
//  mem_wr_n      out  1       bus write enable, active low
//  mem_mask      out  4       byte-lane enables
//  mem_addr      out  ADDR_W  word-aligned address (addr[1:0]=0)
//  mem_wdata     out  32      lane-aligned store data
//  mem_rdata     in   32      read data, sampled when mem_ready=1
//  mem_ready     in   1       responder completes current beat
// BEHAVIOUR
//  States: IDLE, BEAT1, BEAT2, DONE. Bus outputs and load_data are registered.
//  Reset: IDLE. mem_cs_n=1, mem_wr_n=1, all other outputs 0.
//  IDLE, req_valid=1: capture the request.
//   - Illegal or (macro off and misaligned): go to DONE with the error flag set; the bus is never driven.
//   - Otherwise: go to BEAT1 and drive the bus on the next edge.
//  BEAT1/BEAT2: hold mem_cs_n=0 and mem_wr_n=!store until mem_ready=1.
//   - Sample mem_rdata on the mem_ready cycle and deassert cs on the following edge.
//   - Then go to BEAT2 if split, else DONE.
//  Timeout: wait counter resets at each beat start. At TIMEOUT cycles without ready: set err_bus, go to DONE.
//   - A timed-out store may be partially written; no retry.
//  DONE: resp_valid=1 for exactly one cycle, then IDLE. req_valid in DONE is ignored.
//  stall = (IDLE & req_valid) | BEAT1 | BEAT2; stall=0 in DONE. Min latency: 3 cycles with ready tied 1.
//  Alignment, off = addr[1:0]:
//   - Mask: B = 0001<<off, H = 0011<<off, W = 1111. wdata = req_wdata<<(8*off).
//   - Load: word>>(8*off), then low byte/half; B/H sign-extend, BU/HU zero-extend.
//   - Misaligned: H with off=3; W with off!=0. (H with off=1 fits in one word and is aligned here.)
//  Error responses: load_data=0; errors mutually exclusive; priority illegal > misalign > bus.
//  Reset mid-access: immediate IDLE, bus released asynchronously; no response is issued.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: misaligned accesses run as two beats.
//   - Beat 1 at addr&~3, mask (full_mask<<off)[3:0]; beat 2 at (addr&~3)+4, mask full_mask>>(4-off).
//   - Store data: wdata<<8off, then wdata>>(32-8off). Load: {rdata2,rdata1}>>(8*off), then extend.
//   - err_misalign is never raised; address wrap past max wraps to 0.
//  Not defined: misaligned -> err_misalign in DONE, no beats; the BEAT2 state is unreachable and may be optimised out.
// STRUCTURE
//  lsu_pkg: state enum, funct3 constants (F3_B..F3_HU), size_mask() function, lsu_req_t struct.
//  Sub-module lsu_align (combinational): store mask/shift and load extract/extend; instantiated once.
// TESTING
//  1. SW addr 0x10, wdata 0xDEADBEEF, ready=1 -> cs_n=0, wr_n=0, mask 1111, mem_addr 0x10; stall 2 cycles, resp_valid in cycle 3.
//  2. Word 0x80FF7F01; LB @0x3 -> 0xFFFFFF80; LBU @0x3 -> 0x00000080; LH @0x2 -> 0xFFFF80FF; LHU @0x0 -> 0x00007F01.
//  3. SB addr 0x6, wdata 0xAB -> mask 0100, mem_addr 0x4, mem_wdata 0x00AB0000.
//  4. LW addr 0x5. Macro off -> err_misalign, cs_n stays 1. Macro on -> beats 0x4/mask 1110 and 0x8/mask 0001; {0x00000044,0x332211xx} -> 0x44332211.
//  5. mem_ready held 0 -> err_bus after 16 cycles, cs_n=1 next, load_data=0; rst asserted mid-beat -> cs_n=1 immediately, no resp_valid.
//  6. funct3 011 load -> err_illegal, no bus activity; back-to-back requests -> each produces exactly one resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and decode helpers for the MEM-stage load/store initiator
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Captured request; the word address lives in the bus address register.
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // Unshifted byte-lane mask for an access size.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Unsigned variants only exist for loads; 011/110/111 exist for neither.
  function automatic logic is_illegal(input logic [2:0] f3, input logic store);
    is_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
  endfunction

  // A halfword at offset 1 still sits inside one word, so only offset 3 crosses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    is_misaligned = ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
                    ((f3[1:0] == 2'b10) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane alignment and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  mask_o,
  output logic [63:0] wdata_o,
  output logic [31:0] load_o
);

  logic [5:0]  shamt;
  logic [31:0] rshift;

  // Lanes/data over a two-word window: low half is beat 1, high half beat 2.
  assign shamt   = {off_i, 3'b000};
  assign mask_o  = {4'b0000, size_mask(funct3_i)} << off_i;
  assign wdata_o = {32'h0, wdata_i} << shamt;
  assign rshift  = 32'(rdata_i >> shamt);

  // Pick the low byte/half of the shifted word and extend it.
  always_comb begin
    load_o = rshift;
    case (funct3_i)
      F3_B:    load_o = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    load_o = {{16{rshift[15]}}, rshift[15:0]};
      F3_BU:   load_o = {24'h0, rshift[7:0]};
      F3_HU:   load_o = {16'h0, rshift[15:0]};
      default: load_o = rshift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - MEM-stage load/store bus initiator; LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              err_misalign,
  output logic              err_bus,
  output logic              err_illegal,
  output logic              mem_cs_n,
  output logic              mem_wr_n,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              split_q, split_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, load_q, load_d;
  logic              err_mis_q, err_mis_d, err_bus_q, err_bus_d, err_ill_q, err_ill_d;

  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata, al_load;
  logic [63:0]       al_rdata, al_wsh;
  logic [7:0]        al_mask;
  logic              req_ill, req_mis;

  // In IDLE the aligner sees the live request so beat 1 can launch on the capture edge.
  assign al_f3    = (state_q == S_IDLE) ? req_funct3 : req_q.funct3;
  assign al_off   = (state_q == S_IDLE) ? req_addr[1:0] : req_q.off;
  assign al_wdata = (state_q == S_IDLE) ? req_wdata : req_q.wdata;
  assign al_rdata = split_q ? {mem_rdata, rdata1_q} : {32'h0, mem_rdata};
  assign req_ill  = is_illegal(req_funct3, req_store);
  assign req_mis  = is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3_i (al_f3),
    .off_i    (al_off),
    .wdata_i  (al_wdata),
    .rdata_i  (al_rdata),
    .mask_o   (al_mask),
    .wdata_o  (al_wsh),
    .load_o   (al_load)
  );

  // Next-state, bus drive, beat sequencing and timeout.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    split_d   = split_q;
    rdata1_d  = rdata1_q;
    cnt_d     = cnt_q;
    cs_n_d    = cs_n_q;
    wr_n_d    = wr_n_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    err_mis_d = err_mis_q;
    err_bus_d = err_bus_q;
    err_ill_d = err_ill_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{store: req_store, funct3: req_funct3, off: req_addr[1:0], wdata: req_wdata};
          split_d = 1'b0;
          if (req_ill) begin
            err_ill_d = 1'b1;
            state_d   = S_DONE;
`ifndef LSU_MISALIGN_SPLIT_EN
          end else if (req_mis) begin
            err_mis_d = 1'b1;
            state_d   = S_DONE;
`endif
          end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d = req_mis;
`endif
            state_d = S_BEAT1;
            cs_n_d  = 1'b0;
            wr_n_d  = !req_store;
            mask_d  = al_mask[3:0];
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = al_wsh[31:0];
            cnt_d   = '0;
          end
        end
      end
      S_BEAT1, S_BEAT2: begin
        if (mem_ready) begin
          rdata1_d = mem_rdata;
          if ((state_q == S_BEAT1) && split_q) begin
            state_d = S_BEAT2;
            mask_d  = al_mask[7:4];
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = al_wsh[63:32];
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            mask_d  = 4'b0000;
            load_d  = req_q.store ? 32'h0 : al_load;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          err_bus_d = 1'b1;
          cs_n_d    = 1'b1;
          wr_n_d    = 1'b1;
          mask_d    = 4'b0000;
          load_d    = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        load_d    = 32'h0;
        err_mis_d = 1'b0;
        err_bus_d = 1'b0;
        err_ill_d = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs; reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      split_q   <= 1'b0;
      rdata1_q  <= 32'h0;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      mask_q    <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      load_q    <= 32'h0;
      err_mis_q <= 1'b0;
      err_bus_q <= 1'b0;
      err_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      split_q   <= split_d;
      rdata1_q  <= rdata1_d;
      cnt_q     <= cnt_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      err_mis_q <= err_mis_d;
      err_bus_q <= err_bus_d;
      err_ill_q <= err_ill_d;
    end
  end

  assign stall        = ((state_q == S_IDLE) && req_valid) || (state_q == S_BEAT1) || (state_q == S_BEAT2);
  assign resp_valid   = (state_q == S_DONE);
  assign load_data    = load_q;
  assign err_misalign = err_mis_q;
  assign err_bus      = err_bus_q;
  assign err_illegal  = err_ill_q;
  assign mem_cs_n     = cs_n_q;
  assign mem_wr_n     = wr_n_q;
  assign mem_mask     = mask_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule
